// File: rtl/mnisc_act_pkg.sv
// Shared definitions for the activation packing path.
// Holds the code width, the packer state encoding and the act_bits helpers
// used by act_row_packer and act_code_slicer.
package mnisc_act_pkg;

  // Every activation is cut into codes of this many bits.
  localparam int unsigned CODE_W = 2;

  // Packer states. Plain localparams keep the encoding visible to older tools.
  typedef logic [1:0] apk_state_e;
  localparam apk_state_e ST_IDLE  = 2'd0;
  localparam apk_state_e ST_RUN   = 2'd1;
  localparam apk_state_e ST_DRAIN = 2'd2;
  localparam apk_state_e ST_DONE  = 2'd3;

  // Only these widths give a slice count that is a power of two dividing a beat.
  function automatic logic act_bits_legal(input logic [7:0] bits);
    return (bits == 8'd2) || (bits == 8'd4) || (bits == 8'd8) || (bits == 8'd16);
  endfunction

  // Number of 2-bit codes per element.
  function automatic logic [7:0] act_slices(input logic [7:0] bits);
    return bits >> 1;
  endfunction

endpackage

// File: rtl/act_code_slicer.sv
// Combinational slicer: places the low 2*S bits of one element at code position
// code_cnt of a beat, LSB slice first.
// Ports:
//   elem_i      element to slice (only the low 2*slices_i bits are used)
//   slices_i    codes per element, S in {1,2,4,8}
//   code_cnt_i  first code position written by this element
//   wr_mask_o   bits of the beat written by this element
//   wr_data_o   element codes at their beat position, zero elsewhere
module act_code_slicer
  import mnisc_act_pkg::*;
#(
  parameter int unsigned OUT_W  = 128,
  parameter int unsigned ELEM_W = 16
) (
  input  logic [ELEM_W-1:0]                   elem_i,
  input  logic [3:0]                          slices_i,
  input  logic [$clog2(OUT_W/CODE_W)-1:0]     code_cnt_i,
  output logic [OUT_W-1:0]                    wr_mask_o,
  output logic [OUT_W-1:0]                    wr_data_o
);

  logic [ELEM_W-1:0] lane_mask;

  always_comb begin
    // Shifting all-ones left by 2*S clears the used lane; a shift of the full width
    // (S=8 with 16-bit elements) yields zero, so the inverse is all-ones as needed.
    lane_mask = ~({ELEM_W{1'b1}} << {slices_i, 1'b0});
    wr_mask_o = OUT_W'(lane_mask) << {code_cnt_i, 1'b0};
    wr_data_o = OUT_W'(elem_i & lane_mask) << {code_cnt_i, 1'b0};
  end

endmodule

// File: rtl/act_row_packer.sv
// Activation row packer: slices a (y, x, ic) element stream into 2-bit codes and
// packs them into OUT_W-bit beats for the conv3x3 line buffer. Each input row ends
// on a beat boundary (zero padded) and beats carry row/frame-last tags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_w_in_i/h_in_i/ic_i     frame geometry, latched on an accepted start
//   cfg_act_bits_i             element width in bits (2/4/8/16), latched on start
//   start_i                    begin a frame (only honoured when idle)
//   busy_o/done_o/cfg_err_o    status; done and cfg_err are single-cycle pulses
//   elem_data_i/valid_i/ready_o element stream
//   act_out_data_o/valid_o/ready_i packed beat stream, code k in bits [2k+1:2k]
//   act_out_row_last_o/frame_last_o beat tags
module act_row_packer
  import mnisc_act_pkg::*;
#(
  parameter int unsigned OUT_W  = 128,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned MAX_W  = 256,
  parameter int unsigned MAX_IC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cfg_w_in_i,
  input  logic [15:0]       cfg_h_in_i,
  input  logic [15:0]       cfg_ic_i,
  input  logic [7:0]        cfg_act_bits_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  input  logic [ELEM_W-1:0] elem_data_i,
  input  logic              elem_valid_i,
  output logic              elem_ready_o,
  output logic [OUT_W-1:0]  act_out_data_o,
  output logic              act_out_valid_o,
  input  logic              act_out_ready_i,
  output logic              act_out_row_last_o,
  output logic              act_out_frame_last_o
);

  localparam int unsigned CodesPerBeat = OUT_W / CODE_W;
  localparam int unsigned CntW         = $clog2(CodesPerBeat);
  localparam int unsigned ElemCntW     = $clog2(MAX_W * MAX_IC) + 1;

  apk_state_e          state_q, state_d;
  logic [ElemCntW-1:0] row_len_q, row_len_d;
  logic [15:0]         h_q, h_d;
  logic [3:0]          s_q, s_d;
  logic [ElemCntW-1:0] elem_cnt_q, elem_cnt_d;
  logic [15:0]         row_cnt_q, row_cnt_d;
  logic [OUT_W-1:0]    pack_q, pack_d;
  logic [CntW-1:0]     code_cnt_q, code_cnt_d;
  logic                slot_valid_q, slot_valid_d;
  logic [OUT_W-1:0]    slot_data_q, slot_data_d;
  logic                slot_row_last_q, slot_row_last_d;
  logic                slot_frame_last_q, slot_frame_last_d;
  logic                cfg_err_q, cfg_err_d;

  logic [OUT_W-1:0] wr_mask, wr_data, merged;
  logic             elem_hs, row_end, frame_end, beat_full, beat_close, slot_drain;

  act_code_slicer #(
    .OUT_W  (OUT_W),
    .ELEM_W (ELEM_W)
  ) u_slicer (
    .elem_i     (elem_data_i),
    .slices_i   (s_q),
    .code_cnt_i (code_cnt_q),
    .wr_mask_o  (wr_mask),
    .wr_data_o  (wr_data)
  );

  always_comb begin
    merged     = (pack_q & ~wr_mask) | wr_data;
    row_end    = (elem_cnt_q == row_len_q - ElemCntW'(1));
    frame_end  = row_end && (row_cnt_q == h_q - 16'd1);
    beat_full  = ((CntW + 1)'(code_cnt_q) + (CntW + 1)'(s_q)) == (CntW + 1)'(CodesPerBeat);
    beat_close = beat_full || row_end;
    slot_drain = slot_valid_q && act_out_ready_i;
    // Stall only an element that would need the slot while it is still occupied.
    elem_ready_o = (state_q == ST_RUN) && !(beat_close && slot_valid_q && !act_out_ready_i);
    elem_hs      = elem_valid_i && elem_ready_o;
  end

  always_comb begin
    state_d           = state_q;
    row_len_d         = row_len_q;
    h_d               = h_q;
    s_d               = s_q;
    elem_cnt_d        = elem_cnt_q;
    row_cnt_d         = row_cnt_q;
    pack_d            = pack_q;
    code_cnt_d        = code_cnt_q;
    slot_valid_d      = slot_valid_q;
    slot_data_d       = slot_data_q;
    slot_row_last_d   = slot_row_last_q;
    slot_frame_last_d = slot_frame_last_q;
    cfg_err_d         = 1'b0;

    if (slot_drain) begin
      slot_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (!act_bits_legal(cfg_act_bits_i)) begin
            cfg_err_d = 1'b1;
          end else begin
            s_d        = 4'(act_slices(cfg_act_bits_i));
            h_d        = cfg_h_in_i;
            row_len_d  = ElemCntW'(cfg_w_in_i) * ElemCntW'(cfg_ic_i);
            elem_cnt_d = '0;
            row_cnt_d  = '0;
            pack_d     = '0;
            code_cnt_d = '0;
            if ((cfg_w_in_i == 16'd0) || (cfg_h_in_i == 16'd0) || (cfg_ic_i == 16'd0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
      end

      ST_RUN: begin
        if (elem_hs) begin
          if (beat_close) begin
            // Load wins over the drain above when both happen in one cycle.
            slot_valid_d      = 1'b1;
            slot_data_d       = merged;
            slot_row_last_d   = row_end;
            slot_frame_last_d = frame_end;
            pack_d            = '0;
            code_cnt_d        = '0;
          end else begin
            pack_d     = merged;
            code_cnt_d = code_cnt_q + CntW'(s_q);
          end
          if (row_end) begin
            elem_cnt_d = '0;
            row_cnt_d  = row_cnt_q + 16'd1;
            if (frame_end) begin
              state_d = ST_DRAIN;
            end
          end else begin
            elem_cnt_d = elem_cnt_q + ElemCntW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (slot_drain && slot_frame_last_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      row_len_q         <= '0;
      h_q               <= '0;
      s_q               <= '0;
      elem_cnt_q        <= '0;
      row_cnt_q         <= '0;
      pack_q            <= '0;
      code_cnt_q        <= '0;
      slot_valid_q      <= 1'b0;
      slot_data_q       <= '0;
      slot_row_last_q   <= 1'b0;
      slot_frame_last_q <= 1'b0;
      cfg_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      row_len_q         <= row_len_d;
      h_q               <= h_d;
      s_q               <= s_d;
      elem_cnt_q        <= elem_cnt_d;
      row_cnt_q         <= row_cnt_d;
      pack_q            <= pack_d;
      code_cnt_q        <= code_cnt_d;
      slot_valid_q      <= slot_valid_d;
      slot_data_q       <= slot_data_d;
      slot_row_last_q   <= slot_row_last_d;
      slot_frame_last_q <= slot_frame_last_d;
      cfg_err_q         <= cfg_err_d;
    end
  end

  assign busy_o               = (state_q != ST_IDLE);
  assign done_o               = (state_q == ST_DONE);
  assign cfg_err_o            = cfg_err_q;
  assign act_out_valid_o      = slot_valid_q;
  assign act_out_data_o       = slot_data_q;
  assign act_out_row_last_o   = slot_row_last_q;
  assign act_out_frame_last_o = slot_frame_last_q;

endmodule

// File: tb/tb_act_row_packer.sv
`timescale 1ns/1ps
module tb_act_row_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  cfg_w_in_i = '0, cfg_h_in_i = '0, cfg_ic_i = '0;
  logic [7:0]   cfg_act_bits_i = '0;
  logic         start_i = 1'b0;
  logic         busy_o, done_o, cfg_err_o;
  logic [15:0]  elem_data_i = '0;
  logic         elem_valid_i = 1'b0;
  logic         elem_ready_o;
  logic [127:0] act_out_data_o;
  logic         act_out_valid_o;
  logic         act_out_ready_i = 1'b1;
  logic         act_out_row_last_o, act_out_frame_last_o;

  always #5 clk = ~clk;

  act_row_packer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_w_in_i           (cfg_w_in_i),
    .cfg_h_in_i           (cfg_h_in_i),
    .cfg_ic_i             (cfg_ic_i),
    .cfg_act_bits_i       (cfg_act_bits_i),
    .start_i              (start_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .cfg_err_o            (cfg_err_o),
    .elem_data_i          (elem_data_i),
    .elem_valid_i         (elem_valid_i),
    .elem_ready_o         (elem_ready_o),
    .act_out_data_o       (act_out_data_o),
    .act_out_valid_o      (act_out_valid_o),
    .act_out_ready_i      (act_out_ready_i),
    .act_out_row_last_o   (act_out_row_last_o),
    .act_out_frame_last_o (act_out_frame_last_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Beat capture and protocol observation, sampled mid-cycle.
  logic [127:0] got_data[$];
  logic         got_rl[$];
  logic         got_fl[$];
  int           hold_viol = 0;
  int           stall_cnt = 0;
  logic         prev_stalled = 1'b0;
  logic [129:0] prev_beat = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stalled && (!act_out_valid_o ||
          {act_out_data_o, act_out_row_last_o, act_out_frame_last_o} !== prev_beat)) begin
        hold_viol++;
      end
      prev_stalled = act_out_valid_o && !act_out_ready_i;
      prev_beat    = {act_out_data_o, act_out_row_last_o, act_out_frame_last_o};
      if (act_out_valid_o && act_out_ready_i) begin
        got_data.push_back(act_out_data_o);
        got_rl.push_back(act_out_row_last_o);
        got_fl.push_back(act_out_frame_last_o);
      end
      if (elem_valid_i && !elem_ready_o && busy_o) stall_cnt++;
    end else begin
      prev_stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0]  elems[$];
  logic [127:0] exp_data[$];
  logic         exp_rl[$];
  logic         exp_fl[$];
  int           acc_snap = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_rl.delete();
    got_fl.delete();
    hold_viol = 0;
    stall_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] w, input logic [15:0] h, input logic [15:0] ic,
                          input logic [7:0] bits);
    cfg_w_in_i     = w;
    cfg_h_in_i     = h;
    cfg_ic_i       = ic;
    cfg_act_bits_i = bits;
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
  endtask

  // Feed every entry of elems; ready is held low for the first low_cyc cycles.
  task automatic stream(input bit rnd, input int low_cyc, input int snap_cyc, input int budget);
    int idx = 0;
    int c = 0;
    bit acc;
    while (idx < elems.size() && c < budget) begin
      elem_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      elem_data_i  = elems[idx];
      if (c < low_cyc) act_out_ready_i = 1'b0;
      else act_out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == snap_cyc) acc_snap = idx;
      @(negedge clk);
      acc = elem_valid_i && elem_ready_o;
      tick();
      if (acc) idx++;
      c++;
    end
    elem_valid_i = 1'b0;
    chk("stream_all_accepted", idx, elems.size());
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int c = 0;
    while (!done_o && c < budget) begin
      act_out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    chk("done_seen", done_o, 1'b1);
    act_out_ready_i = 1'b1;
    tick();
    chk("done_one_cycle", done_o, 1'b0);
    chk("idle_after_done", busy_o, 1'b0);
  endtask

  // Reference packing: code by code, rows padded to a whole beat.
  task automatic build_exp(input int s, input int row_len, input int h);
    logic [127:0] beat;
    logic [15:0]  v;
    int           pos;
    exp_data.delete();
    exp_rl.delete();
    exp_fl.delete();
    for (int r = 0; r < h; r++) begin
      beat = '0;
      pos  = 0;
      for (int e = 0; e < row_len; e++) begin
        v = elems[r * row_len + e];
        for (int sl = 0; sl < s; sl++) begin
          beat[2 * pos +: 2] = v[2 * sl +: 2];
          pos++;
        end
        if (pos == 64 || e == row_len - 1) begin
          exp_data.push_back(beat);
          exp_rl.push_back(e == row_len - 1);
          exp_fl.push_back((e == row_len - 1) && (r == h - 1));
          beat = '0;
          pos  = 0;
        end
      end
    end
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_nbeats"}, got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_rl%0d", tag, i), got_rl[i], exp_rl[i]);
      chk($sformatf("%s_fl%0d", tag, i), got_fl[i], exp_fl[i]);
    end
  endtask

  task automatic t1_frame(input string tag);
    logic [127:0] e4;
    e4 = {16{8'hE4}};
    clear_mon();
    elems.delete();
    for (int i = 0; i < 64; i++) elems.push_back(16'hFF00 + 16'(i));
    do_start(16'd4, 16'd1, 16'd16, 8'd2);
    stream(1'b0, 0, -1, 500);
    wait_done(1'b0, 50);
    chk({tag, "_nbeats"}, got_data.size(), 1);
    if (got_data.size() > 0) begin
      chk({tag, "_data"}, got_data[0], e4);
      chk({tag, "_row_last"}, got_rl[0], 1'b1);
      chk({tag, "_frame_last"}, got_fl[0], 1'b1);
    end
  endtask

  initial begin
    logic [127:0] b0, b1, b3;
    int bits_tab[4];
    bits_tab = '{2, 4, 8, 16};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_cfg_err", cfg_err_o, 1'b0);
    chk("rst_valid", act_out_valid_o, 1'b0);
    chk("rst_data", act_out_data_o, 128'h0);
    chk("rst_elem_ready", elem_ready_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: one full beat of 2-bit codes
    t1_frame("t1");

    // 2: 8-bit elements, two rows of 36 codes each, upper element bits ignored
    clear_mon();
    elems.delete();
    for (int i = 1; i <= 18; i++) elems.push_back({8'h5A, 8'(i)});
    do_start(16'd3, 16'd2, 16'd3, 8'd8);
    stream(1'b0, 0, -1, 500);
    wait_done(1'b0, 50);
    b0 = 128'h00000000000000090807060504030201;
    b1 = 128'h000000000000001211100F0E0D0C0B0A;
    chk("t2_nbeats", got_data.size(), 2);
    if (got_data.size() == 2) begin
      chk("t2_beat0", got_data[0], b0);
      chk("t2_beat1", got_data[1], b1);
      chk("t2_rl0", got_rl[0], 1'b1);
      chk("t2_fl0", got_fl[0], 1'b0);
      chk("t2_rl1", got_rl[1], 1'b1);
      chk("t2_fl1", got_fl[1], 1'b1);
    end

    // 3: 16-bit elements with output back-pressure for the first 20 cycles
    clear_mon();
    elems.delete();
    for (int i = 0; i < 128; i++) elems.push_back(16'hA500 + 16'(i));
    do_start(16'd8, 16'd1, 16'd16, 8'd16);
    stream(1'b0, 20, 20, 1000);
    wait_done(1'b0, 50);
    chk("t3_accepted_at_20", acc_snap, 15);
    chk("t3_stall_cycles", stall_cnt, 5);
    chk("t3_hold_violations", hold_viol, 0);
    b3 = 128'hA507A506A505A504A503A502A501A500;
    if (got_data.size() > 0) chk("t3_beat0", got_data[0], b3);
    build_exp(8, 128, 1);
    cmp_beats("t3");

    // 4: illegal act_bits, then a zero-channel frame
    clear_mon();
    do_start(16'd4, 16'd1, 16'd16, 8'd6);
    chk("t4_cfg_err_pulse", cfg_err_o, 1'b1);
    chk("t4_busy_on_err", busy_o, 1'b0);
    tick();
    chk("t4_cfg_err_clear", cfg_err_o, 1'b0);
    do_start(16'd4, 16'd1, 16'd0, 8'd4);
    chk("t4_zero_done", done_o, 1'b1);
    tick();
    chk("t4_zero_done_clear", done_o, 1'b0);
    chk("t4_zero_busy", busy_o, 1'b0);
    chk("t4_zero_nbeats", got_data.size(), 0);

    // 5: random handshakes on both sides for every legal width
    for (int b = 0; b < 4; b++) begin
      clear_mon();
      elems.delete();
      for (int i = 0; i < 105; i++) elems.push_back(16'($urandom));
      do_start(16'd5, 16'd3, 16'd7, 8'(bits_tab[b]));
      stream(1'b1, 0, -1, 5000);
      wait_done(1'b1, 2000);
      build_exp(bits_tab[b] / 2, 35, 3);
      cmp_beats($sformatf("t5_bits%0d", bits_tab[b]));
      chk($sformatf("t5_bits%0d_hold", bits_tab[b]), hold_viol, 0);
    end

    // 6: asynchronous reset in the middle of a row
    clear_mon();
    do_start(16'd4, 16'd2, 16'd16, 8'd4);
    elem_valid_i    = 1'b1;
    act_out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      elem_data_i = 16'hFFFF;
      tick();
    end
    elem_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_elem_ready", elem_ready_o, 1'b0);
    chk("t6_valid", act_out_valid_o, 1'b0);
    chk("t6_data", act_out_data_o, 128'h0);
    chk("t6_row_last", act_out_row_last_o, 1'b0);
    chk("t6_frame_last", act_out_frame_last_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    t1_frame("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
